// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: request opcodes, ALU selects and
// FSM states.
package alu_seq_pkg;

  localparam logic [3:0] OP_SHLN = 4'b1000;
  localparam logic [3:0] OP_SHRN = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_SHR1 = 3'b010;
  localparam logic [2:0] SEL_SHL1 = 3'b011;
  localparam logic [2:0] SEL_ASR  = 3'b100;
  localparam logic [2:0] SEL_AND  = 3'b101;
  localparam logic [2:0] SEL_OR   = 3'b110;
  localparam logic [2:0] SEL_XOR  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_MUL_ADD,
    ST_MUL_SHL,
    ST_DONE
  } state_t;

  // Opcodes 1011..1111 have no meaning.
  function automatic logic is_reserved(input logic [3:0] op);
    return op[3] && (op > OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Single-cycle 32-bit ALU. CarryOut is the add carry, the subtract borrow,
// the bit shifted out by the 1-bit shifts, and 0 for logic ops.
module ALU
  import alu_seq_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALU_Sel,
  output logic [31:0] ALU_Out,
  output logic        CarryOut
);

  logic [32:0] wide;

  always_comb begin
    wide = '0;
    case (ALU_Sel)
      SEL_ADD:  wide = {1'b0, A} + {1'b0, B};
      SEL_SUB:  wide = {1'b0, A} - {1'b0, B};
      SEL_SHR1: wide = {A[0], 1'b0, A[31:1]};
      SEL_SHL1: wide = {A[31], A[30:0], 1'b0};
      SEL_ASR:  wide = {A[0], A[31], A[31:1]};
      SEL_AND:  wide = {1'b0, A & B};
      SEL_OR:   wide = {1'b0, A | B};
      SEL_XOR:  wide = {1'b0, A ^ B};
      default:  wide = '0;
    endcase
  end

  assign ALU_Out  = wide[31:0];
  assign CarryOut = wide[32];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle command sequencer around the shared ALU: native ops in one pass,
// variable shifts and unsigned multiply as repeated single-bit ALU passes.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_neg,
  output logic        rsp_carry,
  output logic        rsp_err
);

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_carry_q, rsp_carry_d, rsp_err_q, rsp_err_d;
  logic               rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d;

  logic [31:0]        alu_a, alu_b, alu_out;
  logic [2:0]         alu_sel;
  logic               alu_carry;

  ALU u_alu (
    .A        (alu_a),
    .B        (alu_b),
    .ALU_Sel  (alu_sel),
    .ALU_Out  (alu_out),
    .CarryOut (alu_carry)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    alu_a       = a_q;
    alu_b       = b_q;
    alu_sel     = op_q[2:0];

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CNT_W'(req_b[4:0]);
          if (req_op == OP_SHLN || req_op == OP_SHRN) begin
            if (req_b[4:0] == 5'd0) begin
              // A zero-count shift degenerates to a pass-through add.
              op_d    = {1'b0, SEL_ADD};
              b_d     = '0;
              state_d = ST_EXEC;
            end else begin
              state_d = ST_SHIFT;
            end
          end else if (req_op == OP_MUL) begin
            state_d = ST_MUL_ADD;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rsp_err_d   = is_reserved(op_q);
        rsp_data_d  = rsp_err_d ? 32'd0 : alu_out;
        rsp_carry_d = rsp_err_d ? 1'b0 : alu_carry;
        state_d     = ST_DONE;
      end
      ST_SHIFT: begin
        alu_sel = (op_q == OP_SHLN) ? SEL_SHL1 : SEL_SHR1;
        a_d     = alu_out;
        carry_d = alu_carry;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry;
          rsp_err_d   = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_MUL_ADD: begin
        if (b_q == 32'd0) begin
          rsp_data_d  = acc_q;
          rsp_carry_d = carry_q;
          rsp_err_d   = 1'b0;
          state_d     = ST_DONE;
        end else begin
          alu_a   = acc_q;
          alu_b   = a_q;
          alu_sel = SEL_ADD;
          if (b_q[0]) begin
            acc_d   = alu_out;
            carry_d = carry_q | alu_carry;
          end
          state_d = ST_MUL_SHL;
        end
      end
      ST_MUL_SHL: begin
        alu_sel = SEL_SHL1;
        a_d     = alu_out;
        b_d     = b_q >> 1;
        state_d = ST_MUL_ADD;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_DONE);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_zero  = (rsp_data_q == 32'd0);
  assign rsp_neg   = rsp_data_q[31];

endmodule
